// File: rtl/exe_mem_req.sv
// EX-stage data-memory request issuer.
// Formats ld/st requests, detects misaligned addresses, runs the req/addr_ok
// handshake and tracks accepted-but-unanswered requests.
module exe_mem_req #(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        es_valid,
  input  logic [3:0]  es_mem_op,
  input  logic [31:0] es_addr,
  input  logic [31:0] es_st_data,
  input  logic        es_ex,
  input  logic        ex_block,
  input  logic        flush,
  input  logic        ms_allowin,
  input  logic        data_sram_addr_ok,
  input  logic        data_sram_data_ok,
  output logic        es_ready_go,
  output logic        ale_ex,
  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [1:0]  data_sram_size,
  output logic [3:0]  data_sram_wstrb,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  output logic [1:0]  outstanding_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_SENT  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  localparam logic [3:0] OP_LD_B  = 4'd1;
  localparam logic [3:0] OP_LD_BU = 4'd2;
  localparam logic [3:0] OP_LD_H  = 4'd3;
  localparam logic [3:0] OP_LD_HU = 4'd4;
  localparam logic [3:0] OP_LD_W  = 4'd5;
  localparam logic [3:0] OP_ST_B  = 4'd6;
  localparam logic [3:0] OP_ST_H  = 4'd7;
  localparam logic [3:0] OP_ST_W  = 4'd8;

  state_t      r_state, w_nxt;
  logic [1:0]  r_cnt;
  logic        r_wr;
  logic [1:0]  r_size;
  logic [3:0]  r_wstrb;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;

  logic        w_is_mem, w_is_h, w_is_w, w_ale;
  logic        w_cnt_ok, w_issue, w_req, w_rg, w_use_latch;
  logic        w_wr;
  logic [1:0]  w_size;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata;

  assign w_is_mem = (es_mem_op >= OP_LD_B) && (es_mem_op <= OP_ST_W);
  assign w_is_h   = (es_mem_op == OP_LD_H) || (es_mem_op == OP_LD_HU) || (es_mem_op == OP_ST_H);
  assign w_is_w   = (es_mem_op == OP_LD_W) || (es_mem_op == OP_ST_W);
  assign w_ale    = es_valid & ((w_is_h & es_addr[0]) | (w_is_w & (es_addr[1:0] != 2'b00)));
  assign w_cnt_ok = int'(r_cnt) < MAX_OUTSTANDING;
  // resetn gates issue so the bus sees no request while reset is held,
  // even if the EX inputs are still active.
  assign w_issue  = resetn & es_valid & w_is_mem & ~w_ale & ~es_ex & ~ex_block & ~flush & w_cnt_ok;

  // Format size/strobe/data from the current EX instruction.
  always_comb begin
    w_wr    = 1'b0;
    w_size  = 2'd0;
    w_wstrb = 4'b0000;
    w_wdata = 32'h0;
    case (es_mem_op)
      OP_LD_B, OP_LD_BU: w_size = 2'd0;
      OP_LD_H, OP_LD_HU: w_size = 2'd1;
      OP_LD_W:           w_size = 2'd2;
      OP_ST_B: begin
        w_wr    = 1'b1;
        w_size  = 2'd0;
        w_wstrb = 4'b0001 << es_addr[1:0];
        w_wdata = {4{es_st_data[7:0]}};
      end
      OP_ST_H: begin
        w_wr    = 1'b1;
        w_size  = 2'd1;
        w_wstrb = es_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{es_st_data[15:0]}};
      end
      OP_ST_W: begin
        w_wr    = 1'b1;
        w_size  = 2'd2;
        w_wstrb = 4'b1111;
        w_wdata = es_st_data;
      end
      default: ;
    endcase
  end

  // Handshake FSM: next state, req and ready_go.
  always_comb begin
    w_nxt       = r_state;
    w_req       = 1'b0;
    w_rg        = 1'b0;
    w_use_latch = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_req = w_issue;
        if (w_issue) begin
          w_rg = data_sram_addr_ok;
          if (data_sram_addr_ok)
            w_nxt = (es_valid & ms_allowin) ? S_IDLE : S_SENT;
          else
            w_nxt = S_REQ;
        end else begin
          // Non-memory or excepting instrs pass straight through; a clean
          // memory op only waits here when the counter is full or flushed.
          w_rg = ~w_is_mem | w_ale | es_ex | ex_block;
        end
      end
      S_REQ: begin
        w_req       = 1'b1;
        w_use_latch = 1'b1;
        if (flush) begin
          w_nxt = data_sram_addr_ok ? S_IDLE : S_DRAIN;
        end else if (data_sram_addr_ok) begin
          w_rg  = 1'b1;
          w_nxt = (es_valid & ms_allowin) ? S_IDLE : S_SENT;
        end
      end
      S_SENT: begin
        w_rg = 1'b1;
        if ((es_valid & ms_allowin) | flush)
          w_nxt = S_IDLE;
      end
      S_DRAIN: begin
        // Bus protocol forbids dropping req before addr_ok, so keep it up.
        w_req       = 1'b1;
        w_use_latch = 1'b1;
        if (data_sram_addr_ok)
          w_nxt = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  // Drive bus fields: latched while waiting, live while issuing, else zero.
  always_comb begin
    data_sram_wr    = 1'b0;
    data_sram_size  = 2'd0;
    data_sram_wstrb = 4'b0000;
    data_sram_addr  = 32'h0;
    data_sram_wdata = 32'h0;
    if (w_use_latch) begin
      data_sram_wr    = r_wr;
      data_sram_size  = r_size;
      data_sram_wstrb = r_wstrb;
      data_sram_addr  = r_addr;
      data_sram_wdata = r_wdata;
    end else if (w_req) begin
      data_sram_wr    = w_wr;
      data_sram_size  = w_size;
      data_sram_wstrb = w_wstrb;
      data_sram_addr  = es_addr;
      data_sram_wdata = w_wdata;
    end
  end

  assign data_sram_req   = w_req;
  assign es_ready_go     = w_rg;
  assign ale_ex          = w_ale;
  assign outstanding_cnt = r_cnt;

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_nxt;
  end

  // Capture request fields on every issue so REQ/DRAIN hold them stable.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr    <= 1'b0;
      r_size  <= 2'd0;
      r_wstrb <= 4'b0000;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
    end else if (r_state == S_IDLE && w_issue) begin
      r_wr    <= w_wr;
      r_size  <= w_size;
      r_wstrb <= w_wstrb;
      r_addr  <= es_addr;
      r_wdata <= w_wdata;
    end
  end

  // Outstanding counter: accept increments, response decrements, never wraps below 0.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= 2'd0;
    end else begin
      case ({w_req & data_sram_addr_ok, data_sram_data_ok & (r_cnt != 2'd0)})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule
